// File: rtl/nn_report_pkg.sv
// Shared constants, state encodings and the class-to-ASCII helper for the
// result UART reporter. Honours the REPORT_CRLF_EN macro (CR/LF trailer).
package nn_report_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
`ifdef REPORT_CRLF_EN
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam int unsigned MSG_LEN    = 3;
`else
  localparam int unsigned MSG_LEN    = 1;
`endif

  typedef enum logic [1:0] {
    TOP_IDLE   = 2'd0,
    TOP_LOAD   = 2'd1,
    TOP_WAIT   = 2'd2,
    TOP_FINISH = 2'd3
  } top_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // Digits map to '0'..'9'; anything the network cannot name becomes '?'.
  function automatic logic [7:0] class_char(input logic [3:0] cls);
    logic [7:0] c;
    if (cls <= 4'd9) begin
      c = ASCII_ZERO + {4'd0, cls};
    end else begin
      c = ASCII_QMARK;
    end
    return c;
  endfunction

endpackage

// File: rtl/result_uart_reporter_if.sv
// Result handshake between the inference core (master) and the reporter (slave).
interface result_uart_reporter_if;
  logic       result_valid;
  logic [3:0] result_class;
  logic       busy;

  modport master (output result_valid, output result_class, input busy);
  modport slave  (input result_valid, input result_class, output busy);
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: start bit, 8 data bits LSB first, stop bit, then a
// one-cycle done pulse. The line output is registered and idles high.
module uart_tx_byte
  import nn_report_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5209
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx_serial,
  output logic       done
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_t   state_r;
  tx_state_t   state_next_s;
  logic [15:0] clk_cnt_r;
  logic [2:0]  bit_idx_r;
  logic [7:0]  shift_r;
  logic [7:0]  shift_next_s;
  logic        tx_r;
  logic        tx_next_s;
  logic        done_r;
  logic        done_next_s;
  logic        bit_end_s;

  assign bit_end_s = (clk_cnt_r == BIT_LAST);
  assign tx_serial = tx_r;
  assign done      = done_r;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_r <= TX_IDLE;
    else         state_r <= state_next_s;
  end

  // Next state: each phase ends on the bit-timer terminal count.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      TX_IDLE:  if (start) state_next_s = TX_START; else state_next_s = TX_IDLE;
      TX_START: if (bit_end_s) state_next_s = TX_DATA; else state_next_s = TX_START;
      TX_DATA:  if (bit_end_s && (bit_idx_r == 3'd7)) state_next_s = TX_STOP;
                else state_next_s = TX_DATA;
      TX_STOP:  if (bit_end_s) state_next_s = TX_IDLE; else state_next_s = TX_STOP;
      default:  state_next_s = TX_IDLE;
    endcase
  end

  // Output decode: next line level and done, computed ahead so they register cleanly.
  always_comb begin
    shift_next_s = shift_r;
    tx_next_s    = 1'b1;
    done_next_s  = 1'b0;
    if (state_r == TX_IDLE && start) begin
      shift_next_s = data;
    end else if (state_r == TX_DATA && bit_end_s) begin
      shift_next_s = {1'b1, shift_r[7:1]};
    end else begin
      shift_next_s = shift_r;
    end
    case (state_next_s)
      TX_START: tx_next_s = 1'b0;
      TX_DATA:  tx_next_s = shift_next_s[0];
      default:  tx_next_s = 1'b1;
    endcase
    done_next_s = (state_r == TX_STOP) && bit_end_s;
  end

  // Bit timer, bit index, shift register and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_cnt_r <= 16'd0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'hFF;
      tx_r      <= 1'b1;
      done_r    <= 1'b0;
    end else begin
      shift_r <= shift_next_s;
      tx_r    <= tx_next_s;
      done_r  <= done_next_s;
      if (state_r == TX_IDLE || bit_end_s) clk_cnt_r <= 16'd0;
      else                                 clk_cnt_r <= clk_cnt_r + 16'd1;
      if (state_r != TX_DATA) bit_idx_r <= 3'd0;
      else if (bit_end_s)     bit_idx_r <= bit_idx_r + 3'd1;
      else                    bit_idx_r <= bit_idx_r;
    end
  end

endmodule

// File: rtl/result_uart_reporter.sv
// Reports each accepted argmax class as ASCII over UART, counts completed
// reports and flags results dropped while busy. REPORT_CRLF_EN appends CR/LF.
module result_uart_reporter
  import nn_report_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5209
) (
  input  logic                   clk,
  input  logic                   resetn,
  result_uart_reporter_if.slave  res,
  output logic                   tx_serial,
  output logic [7:0]             sent_count,
  output logic                   overrun
);

  top_state_t state_r;
  top_state_t state_next_s;
  logic [3:0] cls_r;
  logic       busy_r;
  logic [7:0] sent_count_r;
  logic       overrun_r;
  logic       accept_s;
  logic       start_s;
  logic [7:0] byte_s;
  logic       tx_done_s;
  logic       last_byte_s;

  assign accept_s   = res.result_valid && !busy_r && (state_r == TOP_IDLE);
  assign res.busy   = busy_r;
  assign sent_count = sent_count_r;
  assign overrun    = overrun_r;

`ifdef REPORT_CRLF_EN
  logic [1:0] byte_idx_r;
  assign last_byte_s = (byte_idx_r == 2'(MSG_LEN - 1));

  // Message byte pointer: restarts on acceptance, steps after each byte.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                             byte_idx_r <= 2'd0;
    else if (accept_s)                                       byte_idx_r <= 2'd0;
    else if (state_r == TOP_WAIT && tx_done_s && !last_byte_s) byte_idx_r <= byte_idx_r + 2'd1;
    else                                                     byte_idx_r <= byte_idx_r;
  end
`else
  assign last_byte_s = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_r <= TOP_IDLE;
    else         state_r <= state_next_s;
  end

  // Next state: accept, start a byte, wait for it, repeat or finish.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      TOP_IDLE:   if (accept_s) state_next_s = TOP_LOAD; else state_next_s = TOP_IDLE;
      TOP_LOAD:   state_next_s = TOP_WAIT;
      TOP_WAIT:   if (!tx_done_s)     state_next_s = TOP_WAIT;
                  else if (last_byte_s) state_next_s = TOP_FINISH;
                  else                state_next_s = TOP_LOAD;
      TOP_FINISH: state_next_s = TOP_IDLE;
      default:    state_next_s = TOP_IDLE;
    endcase
  end

  // Outputs: transmitter start strobe and the current message byte.
  always_comb begin
    start_s = (state_r == TOP_LOAD);
`ifdef REPORT_CRLF_EN
    case (byte_idx_r)
      2'd0:    byte_s = class_char(cls_r);
      2'd1:    byte_s = ASCII_CR;
      2'd2:    byte_s = ASCII_LF;
      default: byte_s = ASCII_QMARK;
    endcase
`else
    byte_s = class_char(cls_r);
`endif
  end

  // Latch accepted class, busy flag, completed-report counter, sticky overrun.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cls_r        <= 4'd0;
      busy_r       <= 1'b0;
      sent_count_r <= 8'd0;
      overrun_r    <= 1'b0;
    end else begin
      if (accept_s) begin
        cls_r  <= res.result_class;
        busy_r <= 1'b1;
      end else if (state_r == TOP_FINISH) begin
        busy_r       <= 1'b0;
        sent_count_r <= sent_count_r + 8'd1;
      end else begin
        busy_r <= busy_r;
      end
      if (res.result_valid && busy_r) overrun_r <= 1'b1;
      else                            overrun_r <= overrun_r;
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start_s),
    .data      (byte_s),
    .tx_serial (tx_serial),
    .done      (tx_done_s)
  );

endmodule

// File: tb/tb_result_uart_reporter.sv
// Directed bench for result_uart_reporter at CLKS_PER_BIT = 4.
`timescale 1ns/1ps
module tb_result_uart_reporter;

  localparam int C = 4;
`ifdef REPORT_CRLF_EN
  localparam int B = 3;
`else
  localparam int B = 1;
`endif
  // Negedge index (0 = just after acceptance edge) where busy first reads low.
  localparam int BUSY_LOW_J = B * 10 * C + 2 * B + 1;

  logic       clk = 1'b0;
  logic       resetn;
  logic       tx_serial;
  logic [7:0] sent_count;
  logic       overrun;

  result_uart_reporter_if rif();

  result_uart_reporter #(.CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .res        (rif),
    .tx_serial  (tx_serial),
    .sent_count (sent_count),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int acc_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the following posedge is the acceptance edge.
  task automatic pulse(input logic [3:0] cls);
    rif.result_valid = 1'b1;
    rif.result_class = cls;
    @(negedge clk);
    rif.result_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  // Waits for a start bit, samples mid-bit, checks the stop bit.
  // inj_k > 0 drives a class-3 result on that cycle of the byte.
  task automatic capture(input string tag, input int inj_k,
                         output logic [7:0] b, output int fall_j);
    int waited = 0;
    b = 8'hxx;
    fall_j = -1;
    while (tx_serial !== 1'b0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (tx_serial === 1'b0) begin
      fall_j = cyc - acc_cyc;
      for (int k = 1; k < 10 * C; k++) begin
        @(negedge clk);
        if (k == inj_k) begin
          rif.result_valid = 1'b1;
          rif.result_class = 4'd3;
        end else begin
          rif.result_valid = 1'b0;
        end
        if (k == 1) chk({tag, "_startbit"}, {31'd0, tx_serial}, 32'd0);
        if (k >= C && k < 9 * C && (k % C) == 2) b[(k / C) - 1] = tx_serial;
        if (k == 9 * C + 1) chk({tag, "_stopbit"}, {31'd0, tx_serial}, 32'd1);
      end
    end
  endtask

  task automatic wait_busy_low(output int j);
    int n = 0;
    j = -1;
    while (rif.busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (rif.busy === 1'b0) j = cyc - acc_cyc;
  endtask

  task automatic run_report(input string tag, input logic [3:0] cls, input logic [7:0] exp0,
                            input int inj_k, input logic [7:0] exp_sent);
    logic [7:0] b;
    int f;
    int j;
    pulse(cls);
    chk({tag, "_busy_rise"}, {31'd0, rif.busy}, 32'd1);
    chk({tag, "_line_high_n1"}, {31'd0, tx_serial}, 32'd1);
    capture(tag, inj_k, b, f);
    chk({tag, "_byte0"}, {24'd0, b}, {24'd0, exp0});
    chk({tag, "_fall0"}, f, 32'd1);
`ifdef REPORT_CRLF_EN
    capture(tag, -1, b, f);
    chk({tag, "_byte1"}, {24'd0, b}, 32'h0D);
    chk({tag, "_fall1"}, f, 1 + 10 * C + 2);
    capture(tag, -1, b, f);
    chk({tag, "_byte2"}, {24'd0, b}, 32'h0A);
    chk({tag, "_fall2"}, f, 1 + 2 * (10 * C + 2));
`endif
    wait_busy_low(j);
    chk({tag, "_busy_fall"}, j, BUSY_LOW_J);
    chk({tag, "_sent"}, {24'd0, sent_count}, {24'd0, exp_sent});
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int j;
    int low_seen;
    resetn = 1'b0;
    rif.result_valid = 1'b0;
    rif.result_class = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx_serial}, 32'd1);
    chk("rst_busy", {31'd0, rif.busy}, 32'd0);
    chk("rst_sent", {24'd0, sent_count}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    run_report("c7", 4'd7, 8'h37, -1, 8'd1);
    chk("c7_ovr", {31'd0, overrun}, 32'd0);
    run_report("c12", 4'd12, 8'h3F, -1, 8'd2);
    run_report("c0", 4'd0, 8'h30, -1, 8'd3);
    run_report("c9", 4'd9, 8'h39, -1, 8'd4);
    run_report("c10", 4'd10, 8'h3F, -1, 8'd5);

    // Second result 10 cycles into the first report is dropped.
    run_report("ovr", 4'd1, 8'h31, 9, 8'd6);
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    low_seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_serial === 1'b0) low_seen++;
    end
    chk("ovr_no_extra_tx", low_seen, 32'd0);
    chk("ovr_sent_once", {24'd0, sent_count}, 32'd6);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);

    // Reset in the middle of data bit 0 of 0x36 (line low).
    pulse(4'd6);
    repeat (6) @(negedge clk);
    chk("mid_line_low", {31'd0, tx_serial}, 32'd0);
    resetn = 1'b0;
    #1;
    chk("mid_rst_tx", {31'd0, tx_serial}, 32'd1);
    chk("mid_rst_busy", {31'd0, rif.busy}, 32'd0);
    chk("mid_rst_sent", {24'd0, sent_count}, 32'd0);
    chk("mid_rst_ovr", {31'd0, overrun}, 32'd0);
    repeat (2) @(negedge clk);
    chk("mid_rst_tx_hold", {31'd0, tx_serial}, 32'd1);
    resetn = 1'b1;
    @(negedge clk);
    run_report("c5", 4'd5, 8'h35, -1, 8'd1);
    chk("c5_ovr", {31'd0, overrun}, 32'd0);

    // Back-to-back: each new result lands on the edge busy first reads low.
    for (int i = 0; i < 256; i++) begin
      pulse(4'(i % 16));
      wait_busy_low(j);
      chk("b2b_latency", j, BUSY_LOW_J);
      chk("b2b_count", {24'd0, sent_count}, {24'd0, 8'((i + 2) % 256)});
    end
    chk("b2b_ovr", {31'd0, overrun}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
